// File: rtl/prog_boot_loader_pkg.sv
// Shared types and constants for the program boot loader.
package prog_boot_loader_pkg;

  typedef enum logic [2:0] {
    HEADER,
    LOAD,
    CHECK,
    RUN,
    ERROR
  } boot_state_e;

  localparam int WORD_BYTES          = 4;
  localparam int CPU_RST_RELEASE_DLY = 2;

endpackage

// File: rtl/prog_boot_loader_if.sv
// Stream, core and instruction-memory signals of the boot loader.
// The master side is the upstream feeder and core; the slave side is the loader.
interface prog_boot_loader_if #(
  parameter int CNT_W = 16
);
  logic             in_valid;
  logic [31:0]      in_data;
  logic             in_ready;
  logic             reload;
  logic [31:0]      cpu_pc;
  logic             cpu_rst;
  logic             imem_wen;
  logic [31:0]      imem_addr;
  logic [31:0]      imem_wdata;
  logic             load_done;
  logic             load_err;
  logic [CNT_W-1:0] words_loaded;

  modport master (
    output in_valid, in_data, reload, cpu_pc,
    input  in_ready, cpu_rst, imem_wen, imem_addr, imem_wdata,
           load_done, load_err, words_loaded
  );

  modport slave (
    input  in_valid, in_data, reload, cpu_pc,
    output in_ready, cpu_rst, imem_wen, imem_addr, imem_wdata,
           load_done, load_err, words_loaded
  );
endinterface

// File: rtl/prog_boot_loader_counter.sv
// boot_stream_counter: write address, payload count and remaining-word tracking.
module boot_stream_counter
  import prog_boot_loader_pkg::*;
#(
  parameter int          CNT_W     = 16,
  parameter logic [31:0] BASE_ADDR = 32'h0000_0000
) (
  input  logic             i_clk,
  input  logic             i_rst,
  input  logic             i_clear,
  input  logic             i_load,
  input  logic             i_inc,
  input  logic [CNT_W-1:0] i_n,
  output logic [31:0]      o_addr,
  output logic [CNT_W-1:0] o_count,
  output logic             o_last
);

  logic [31:0]      r_addr;
  logic [CNT_W-1:0] r_count;
  logic [CNT_W-1:0] r_remaining;

  always_ff @(posedge i_clk) begin
    if (i_rst || i_clear) begin
      r_addr      <= BASE_ADDR;
      r_count     <= '0;
      r_remaining <= '0;
    end else if (i_load) begin
      r_addr      <= BASE_ADDR;
      r_count     <= '0;
      r_remaining <= i_n;
    end else if (i_inc) begin
      r_addr      <= r_addr + 32'(WORD_BYTES);
      r_count     <= r_count + CNT_W'(1);
      r_remaining <= r_remaining - CNT_W'(1);
    end
  end

  assign o_addr  = r_addr;
  assign o_count = r_count;
  assign o_last  = (r_remaining == CNT_W'(1));

endmodule

// File: rtl/prog_boot_loader.sv
// Boot loader: streams a counted program into instruction memory, then releases the core.
// Optional trailing checksum word enabled with `define BOOT_CHECKSUM_EN.
module prog_boot_loader
  import prog_boot_loader_pkg::*;
#(
  parameter int unsigned DEPTH     = 256,
  parameter logic [31:0] BASE_ADDR = 32'h0000_0000,
  parameter int          CNT_W     = 16
) (
  input  logic               i_clk,
  input  logic               i_rst,
  prog_boot_loader_if.slave  bus
);

  localparam logic [1:0] DLY_LAST = 2'(CPU_RST_RELEASE_DLY - 1);

`ifdef BOOT_CHECKSUM_EN
  localparam boot_state_e POST_LOAD = CHECK;
  logic [31:0] r_sum;
`else
  localparam boot_state_e POST_LOAD = RUN;
`endif

  boot_state_e      r_state;
  boot_state_e      w_next;
  logic             w_ready;
  logic             w_xfer;
  logic [CNT_W-1:0] w_n;
  logic             w_ctr_load;
  logic             w_ctr_inc;
  logic             w_wr;
  logic [31:0]      w_addr;
  logic [CNT_W-1:0] w_count;
  logic             w_last;
  logic             r_wen;
  logic [31:0]      r_wdata;
  logic [31:0]      r_waddr;
  logic             r_cpu_rst;
  logic [1:0]       r_dly;

  assign w_ready = (r_state == HEADER) || (r_state == LOAD) || (r_state == CHECK);
  assign w_xfer  = bus.in_valid && w_ready;
  assign w_n     = bus.in_data[CNT_W-1:0];

  boot_stream_counter #(
    .CNT_W     (CNT_W),
    .BASE_ADDR (BASE_ADDR)
  ) u_counter (
    .i_clk   (i_clk),
    .i_rst   (i_rst),
    .i_clear (bus.reload),
    .i_load  (w_ctr_load),
    .i_inc   (w_ctr_inc),
    .i_n     (w_n),
    .o_addr  (w_addr),
    .o_count (w_count),
    .o_last  (w_last)
  );

  always_ff @(posedge i_clk) begin
    if (i_rst) r_state <= HEADER;
    else       r_state <= w_next;
  end

  // reload outranks a simultaneous transfer, so that word is never written
  always_comb begin
    w_next     = r_state;
    w_ctr_load = 1'b0;
    w_ctr_inc  = 1'b0;
    w_wr       = 1'b0;
    if (bus.reload) begin
      w_next = HEADER;
    end else if (w_xfer) begin
      case (r_state)
        HEADER: begin
          w_ctr_load = 1'b1;
          if (w_n == '0)              w_next = POST_LOAD;
          else if (32'(w_n) > DEPTH)  w_next = ERROR;
          else                        w_next = LOAD;
        end
        LOAD: begin
          w_wr      = 1'b1;
          w_ctr_inc = 1'b1;
          if (w_last) w_next = POST_LOAD;
        end
`ifdef BOOT_CHECKSUM_EN
        CHECK: w_next = (bus.in_data == r_sum) ? RUN : ERROR;
`endif
        default: w_next = r_state;
      endcase
    end
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_wen   <= 1'b0;
      r_wdata <= '0;
      r_waddr <= BASE_ADDR;
    end else begin
      r_wen <= w_wr;
      if (w_wr) begin
        r_wdata <= bus.in_data;
        r_waddr <= w_addr;
      end
    end
  end

`ifdef BOOT_CHECKSUM_EN
  always_ff @(posedge i_clk) begin
    if (i_rst || bus.reload || w_ctr_load) r_sum <= '0;
    else if (w_wr)                         r_sum <= r_sum + bus.in_data;
  end
`endif

  // Core reset drops only after the final write has settled in memory
  always_ff @(posedge i_clk) begin
    if (i_rst || bus.reload || (r_state != RUN)) begin
      r_cpu_rst <= 1'b1;
      r_dly     <= '0;
    end else if (r_dly != DLY_LAST) begin
      r_dly <= r_dly + 2'd1;
    end else begin
      r_cpu_rst <= 1'b0;
    end
  end

  assign bus.in_ready     = w_ready;
  assign bus.cpu_rst      = r_cpu_rst;
  assign bus.imem_wen     = r_wen;
  assign bus.imem_wdata   = r_wdata;
  assign bus.imem_addr    = ((r_state == RUN) && !r_cpu_rst) ? bus.cpu_pc : r_waddr;
  assign bus.load_done    = (r_state == RUN);
  assign bus.load_err     = (r_state == ERROR);
  assign bus.words_loaded = w_count;

endmodule

// File: tb/tb_prog_boot_loader.sv
// Directed self-checking bench for prog_boot_loader; memory writes are logged
// from imem_wen and compared against hand-computed addresses and data.
module tb_prog_boot_loader;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   total = 0;
  int   bad   = 0;
  int   cyc   = 0;

  logic [31:0] wrAddr[$];
  logic [31:0] wrData[$];
  int          wrCyc[$];

  prog_boot_loader_if #(.CNT_W(16)) bus ();

  prog_boot_loader #(
    .DEPTH     (256),
    .BASE_ADDR (32'h0000_0000),
    .CNT_W     (16)
  ) dut (
    .i_clk (clk),
    .i_rst (rst),
    .bus   (bus.slave)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  always @(negedge clk) begin
    if (bus.imem_wen) begin
      wrAddr.push_back(bus.imem_addr);
      wrData.push_back(bus.imem_wdata);
      wrCyc.push_back(cyc);
    end
  end

  initial begin
    #500000;
    $display("[TB] FAIL watchdog: got timeout, expected completion");
    $fatal(1, "[TB] watchdog expired");
  end

  task automatic checkOutput(input string tag, input logic [31:0] got, input logic [31:0] want);
    total++;
    if (got !== want) begin
      bad++;
      $display("[TB] FAIL %s: got %h, expected %h", tag, got, want);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic applyStimulus(input logic [31:0] data, input int gap);
    bus.in_valid = 1'b0;
    tick(gap);
    bus.in_valid = 1'b1;
    bus.in_data  = data;
    tick(1);
    bus.in_valid = 1'b0;
  endtask

  task automatic pulseReload();
    bus.reload = 1'b1;
    tick(1);
    bus.reload = 1'b0;
  endtask

  task automatic clearLog();
    wrAddr.delete();
    wrData.delete();
    wrCyc.delete();
  endtask

  task automatic expectWrite(input string tag, input int idx, input logic [31:0] a, input logic [31:0] d);
    if (idx < wrAddr.size()) begin
      checkOutput({tag, " addr"}, wrAddr[idx], a);
      checkOutput({tag, " data"}, wrData[idx], d);
    end else begin
      checkOutput({tag, " present"}, 32'(wrAddr.size()), 32'(idx + 1));
    end
  endtask

  task automatic expectGap(input string tag, input int idx, input int delta);
    if (idx + 1 < wrCyc.size())
      checkOutput(tag, 32'(wrCyc[idx+1] - wrCyc[idx]), 32'(delta));
    else
      checkOutput({tag, " present"}, 32'(wrCyc.size()), 32'(idx + 2));
  endtask

  initial begin
    bus.in_valid = 1'b0;
    bus.in_data  = '0;
    bus.reload   = 1'b0;
    bus.cpu_pc   = 32'h0000_0100;

    tick(2);
    checkOutput("rst cpu_rst",  32'(bus.cpu_rst), 1);
    checkOutput("rst wen",      32'(bus.imem_wen), 0);
    checkOutput("rst wdata",    bus.imem_wdata, 0);
    checkOutput("rst done",     32'(bus.load_done), 0);
    checkOutput("rst err",      32'(bus.load_err), 0);
    checkOutput("rst words",    32'(bus.words_loaded), 0);
    checkOutput("rst in_ready", 32'(bus.in_ready), 1);
    checkOutput("rst addr",     bus.imem_addr, 0);
    rst = 1'b0;
    tick(1);

`ifndef BOOT_CHECKSUM_EN
    // back-to-back three-word load
    clearLog();
    applyStimulus(32'd3, 0);
    applyStimulus(32'h0050_0293, 0);
    applyStimulus(32'h0060_0313, 0);
    applyStimulus(32'h0062_83B3, 0);
    checkOutput("A done",      32'(bus.load_done), 1);
    checkOutput("A last wen",  32'(bus.imem_wen), 1);
    checkOutput("A last addr", bus.imem_addr, 32'h8);
    checkOutput("A cpu_rst0",  32'(bus.cpu_rst), 1);
    tick(1);
    checkOutput("A wen fall",  32'(bus.imem_wen), 0);
    checkOutput("A cpu_rst1",  32'(bus.cpu_rst), 1);
    checkOutput("A addr hold", bus.imem_addr, 32'h8);
    tick(1);
    checkOutput("A cpu_rst2",  32'(bus.cpu_rst), 0);
    checkOutput("A pc mux",    bus.imem_addr, 32'h100);
    bus.cpu_pc = 32'h0000_0044;
    #1;
    checkOutput("A pc follow", bus.imem_addr, 32'h44);
    checkOutput("A nwrites",   32'(wrAddr.size()), 3);
    expectWrite("A w0", 0, 32'h0, 32'h0050_0293);
    expectWrite("A w1", 1, 32'h4, 32'h0060_0313);
    expectWrite("A w2", 2, 32'h8, 32'h0062_83B3);
    expectGap("A gap01", 0, 1);
    expectGap("A gap12", 1, 1);
    checkOutput("A words",     32'(bus.words_loaded), 3);
    checkOutput("A run ready", 32'(bus.in_ready), 0);

    // same stream with two idle cycles between payload words
    pulseReload();
    checkOutput("B reload ready", 32'(bus.in_ready), 1);
    checkOutput("B reload done",  32'(bus.load_done), 0);
    checkOutput("B reload rst",   32'(bus.cpu_rst), 1);
    checkOutput("B reload words", 32'(bus.words_loaded), 0);
    clearLog();
    applyStimulus(32'd3, 0);
    applyStimulus(32'h0050_0293, 0);
    applyStimulus(32'h0060_0313, 2);
    applyStimulus(32'h0062_83B3, 2);
    tick(2);
    checkOutput("B nwrites", 32'(wrAddr.size()), 3);
    expectWrite("B w0", 0, 32'h0, 32'h0050_0293);
    expectWrite("B w1", 1, 32'h4, 32'h0060_0313);
    expectWrite("B w2", 2, 32'h8, 32'h0062_83B3);
    expectGap("B gap01", 0, 3);
    expectGap("B gap12", 1, 3);
    checkOutput("B words", 32'(bus.words_loaded), 3);
    checkOutput("B done",  32'(bus.load_done), 1);

    // empty program
    pulseReload();
    clearLog();
    applyStimulus(32'd0, 0);
    checkOutput("Z done",     32'(bus.load_done), 1);
    checkOutput("Z cpu_rst0", 32'(bus.cpu_rst), 1);
    tick(1);
    checkOutput("Z cpu_rst1", 32'(bus.cpu_rst), 1);
    tick(1);
    checkOutput("Z cpu_rst2", 32'(bus.cpu_rst), 0);
    checkOutput("Z nwrites",  32'(wrAddr.size()), 0);
    checkOutput("Z words",    32'(bus.words_loaded), 0);

    // reload collides with the second payload word of a four-word load
    pulseReload();
    clearLog();
    applyStimulus(32'd4, 0);
    applyStimulus(32'h0000_00A1, 0);
    checkOutput("R words1", 32'(bus.words_loaded), 1);
    bus.reload = 1'b1;
    applyStimulus(32'h0000_00A2, 0);
    bus.reload = 1'b0;
    checkOutput("R ready", 32'(bus.in_ready), 1);
    checkOutput("R done",  32'(bus.load_done), 0);
    checkOutput("R words", 32'(bus.words_loaded), 0);
    checkOutput("R wen",   32'(bus.imem_wen), 0);
    tick(1);
    checkOutput("R nwrites", 32'(wrAddr.size()), 1);
    expectWrite("R w0", 0, 32'h0, 32'h0000_00A1);
    clearLog();
    applyStimulus(32'hFFFF_0002, 0);
    applyStimulus(32'h0000_00B1, 0);
    applyStimulus(32'h0000_00B2, 0);
    tick(1);
    checkOutput("R2 nwrites", 32'(wrAddr.size()), 2);
    expectWrite("R2 w0", 0, 32'h0, 32'h0000_00B1);
    expectWrite("R2 w1", 1, 32'h4, 32'h0000_00B2);
    checkOutput("R2 done",  32'(bus.load_done), 1);
    checkOutput("R2 words", 32'(bus.words_loaded), 2);
`else
    // checksum accepted
    clearLog();
    applyStimulus(32'd2, 0);
    applyStimulus(32'h1, 0);
    applyStimulus(32'h2, 0);
    checkOutput("C check ready", 32'(bus.in_ready), 1);
    checkOutput("C check done",  32'(bus.load_done), 0);
    applyStimulus(32'h3, 0);
    checkOutput("C done",     32'(bus.load_done), 1);
    checkOutput("C cpu_rst0", 32'(bus.cpu_rst), 1);
    tick(2);
    checkOutput("C cpu_rst2", 32'(bus.cpu_rst), 0);
    checkOutput("C nwrites",  32'(wrAddr.size()), 2);
    expectWrite("C w0", 0, 32'h0, 32'h1);
    expectWrite("C w1", 1, 32'h4, 32'h2);

    // checksum rejected
    pulseReload();
    clearLog();
    applyStimulus(32'd2, 0);
    applyStimulus(32'h1, 0);
    applyStimulus(32'h2, 0);
    applyStimulus(32'h4, 0);
    checkOutput("CX err",  32'(bus.load_err), 1);
    checkOutput("CX done", 32'(bus.load_done), 0);
    tick(2);
    checkOutput("CX cpu_rst", 32'(bus.cpu_rst), 1);
    checkOutput("CX nwrites", 32'(wrAddr.size()), 2);
`endif

    // oversize header is rejected and ignores further traffic
    pulseReload();
    clearLog();
    applyStimulus(32'd257, 0);
    checkOutput("E err",     32'(bus.load_err), 1);
    checkOutput("E ready",   32'(bus.in_ready), 0);
    checkOutput("E cpu_rst", 32'(bus.cpu_rst), 1);
    checkOutput("E done",    32'(bus.load_done), 0);
    bus.in_valid = 1'b1;
    bus.in_data  = 32'h0000_0055;
    tick(3);
    bus.in_valid = 1'b0;
    checkOutput("E err hold", 32'(bus.load_err), 1);
    checkOutput("E cpu hold", 32'(bus.cpu_rst), 1);
    checkOutput("E nwrites",  32'(wrAddr.size()), 0);
    checkOutput("E words",    32'(bus.words_loaded), 0);
    pulseReload();
    checkOutput("E reload ready", 32'(bus.in_ready), 1);
    checkOutput("E reload err",   32'(bus.load_err), 0);

    // header exactly DEPTH is accepted into LOAD
    applyStimulus(32'd256, 0);
    checkOutput("D err",   32'(bus.load_err), 0);
    checkOutput("D ready", 32'(bus.in_ready), 1);
    checkOutput("D done",  32'(bus.load_done), 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/prog_boot_loader.md
Name: prog_boot_loader

Overview:
- Upstream feeder of the pipelined core's instruction memory.
- Accepts a program as a valid/ready stream of 32-bit words: one header word giving the word count N, then N instruction words.
- Writes the instruction words into instruction memory at consecutive word-aligned byte addresses.
- Holds the core in reset until the load completes, then hands the memory address port over to the core's PC.

Parameters:
- DEPTH, 256, instruction memory capacity in 32-bit words; a header with N > DEPTH is rejected.
- BASE_ADDR, 32'h0000_0000, byte address of the first loaded word.
- CNT_W, 16, width of the word counter and of the header count field (header bits [CNT_W-1:0]; upper bits ignored).

Ports:
- clk  input  1  clock.
- rst  input  1  synchronous, active-high reset.
- in_valid  input  1  stream word valid.
- in_data  input  32  stream word.
- in_ready  output  1  loader can accept in_data this cycle.
- reload  input  1  single-cycle pulse: restart loading from the header.
- cpu_pc  input  32  core fetch address (pc_out).
- cpu_rst  output  1  reset to the core.
- imem_wen  output  1  instruction memory write enable.
- imem_addr  output  32  instruction memory byte address.
- imem_wdata  output  32  instruction memory write data.
- load_done  output  1  high while in RUN.
- load_err  output  1  high while in ERROR.
- words_loaded  output  CNT_W  payload words written since the last header.

Behaviour:
- One clock domain. Reset is synchronous and active-high on rst, sampled at posedge clk.
- Reset values:
  - state = HEADER, cpu_rst = 1, imem_wen = 0, imem_wdata = 0.
  - load_done = 0, load_err = 0, words_loaded = 0.
  - count = 0, addr register = BASE_ADDR.
- States: HEADER, LOAD, CHECK (only with the macro), RUN, ERROR.
- A transfer occurs when in_valid && in_ready at posedge clk.
- in_ready = 1 in HEADER, LOAD and CHECK; 0 in RUN and ERROR. in_ready is a function of state only, never of in_valid.
- HEADER, on transfer:
  - N = in_data[CNT_W-1:0].
  - N == 0 -> RUN (CHECK if the macro is set).
  - N > DEPTH -> ERROR.
  - Otherwise -> LOAD, with remaining = N, count = 0, addr = BASE_ADDR.
- LOAD, on transfer:
  - Next cycle: imem_wen = 1, imem_wdata = in_data, write address = addr. One-cycle registered latency.
  - Then addr += 4 and words_loaded += 1.
  - On the transfer of the Nth word -> RUN (or CHECK).
  - imem_wen = 0 in every cycle without a preceding transfer, i.e. stalls on in_valid = 0 insert no writes.
- imem_addr mux:
  - Equals the registered write address whenever the state is not RUN.
  - In RUN it equals cpu_pc combinationally.
  - The final write issued on the LOAD->RUN transition completes first: imem_addr switches to cpu_pc one cycle after imem_wen falls.
- RUN:
  - cpu_rst falls 2 cycles after entering RUN, so the last write has landed before the first fetch.
  - load_done = 1 from the first RUN cycle.
  - in_valid is ignored.
- ERROR:
  - cpu_rst stays 1, load_err = 1, no writes.
  - Left only by rst or reload.
- reload, in any state:
  - Next cycle: state = HEADER, cpu_rst = 1, load_done = 0, load_err = 0, words_loaded = 0.
  - reload has priority over a simultaneous transfer; that word is dropped and not written.
- rst mid-load: same as reload. Memory contents already written are left untouched.
- Address arithmetic is 32-bit modulo 2^32. With N ≤ DEPTH, wrap is unreachable when BASE_ADDR + 4*DEPTH ≤ 2^32.

Optional Feature:
- Macro: BOOT_CHECKSUM_EN.
- Defined:
  - A running sum (mod 2^32) of payload words is kept.
  - After the last payload word (or directly after header N=0), the state goes to CHECK and accepts one more word.
  - Word equals the sum -> RUN; otherwise -> ERROR.
  - The checksum word is never written to memory.
- Not defined: CHECK and the sum register do not exist; the last payload word goes directly to RUN.

Decomposition:
- Shared package holds:
  - state enum typedef (HEADER, LOAD, CHECK, RUN, ERROR);
  - WORD_BYTES = 4;
  - CPU_RST_RELEASE_DLY = 2.
- One natural sub-module: boot_stream_counter (addr/count/remaining registers with load and increment), instantiated once.

Test Plan:
- Header 3, words 0x00500293, 0x00600313, 0x006283B3 back-to-back -> writes at 0x0, 0x4, 0x8 on consecutive cycles; load_done rises after the third; cpu_rst falls 2 cycles later; imem_addr then follows cpu_pc.
- Same stream with in_valid low for 2 cycles between words -> identical three writes, with no imem_wen during the gaps; words_loaded = 3.
- Header DEPTH+1 (257) -> ERROR; load_err = 1; cpu_rst stays 1; no writes; subsequent in_valid is ignored; reload pulse returns the block to HEADER with in_ready = 1.
- Header 0 -> RUN with no writes; cpu_rst falls 2 cycles after the header transfer.
- reload asserted together with the 2nd payload word of a 4-word load -> that word is not written; state HEADER; words_loaded = 0; a new load then completes normally.
- With BOOT_CHECKSUM_EN: header 2, words 0x1, 0x2, checksum 0x3 -> RUN. Same stream with checksum 0x4 -> ERROR and cpu_rst held at 1.
